// File: rtl/adler32_checker.sv
`default_nettype none
// ============================================================================
// Module   : adler32_checker
// Purpose  : Recomputes Adler-32 over a payload, captures the 4-byte trailer
//            and reports one pass/fail result per frame.
// Revision : 1.0  initial release
// ============================================================================
module adler32_checker #(
  parameter int unsigned MOD   = 65521,
  parameter logic [15:0] RST_A = 16'd1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        data_valid,
  input  logic        last_data,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        result_valid,
  output logic        checksum_ok,
  output logic [31:0] computed_checksum,
  output logic [31:0] received_checksum
);

  localparam logic [16:0] MOD_W = MOD[16:0];

  typedef enum logic [1:0] {
    ST_PAYLOAD = 2'd0,
    ST_TRAILER = 2'd1,
    ST_RESULT  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] sum_a;
  logic [15:0] sum_b;
  logic [31:0] trailer;
  logic [1:0]  byte_cnt;
  logic        frame_fresh;

  logic        accept;
  logic [15:0] base_a;
  logic [15:0] base_b;
  logic [16:0] a_raw;
  logic [15:0] a_next;
  logic [16:0] b_raw;
  logic [15:0] b_next;
  logic [31:0] trailer_next;

  assign accept = data_valid && ready;

  // The previous result stays visible after RESULT, so the sums are reseeded
  // lazily: the first byte of a new frame starts from RST_A/0, not the registers.
  always_comb begin
    base_a       = frame_fresh ? RST_A : sum_a;
    base_b       = frame_fresh ? 16'd0 : sum_b;
    a_raw        = {1'b0, base_a} + {9'd0, data};
    a_next       = 16'((a_raw >= MOD_W) ? (a_raw - MOD_W) : a_raw);
    b_raw        = {1'b0, base_b} + {1'b0, a_next};
    b_next       = 16'((b_raw >= MOD_W) ? (b_raw - MOD_W) : b_raw);
    trailer_next = {trailer[23:0], data};
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= ST_PAYLOAD;
      sum_a        <= RST_A;
      sum_b        <= 16'd0;
      trailer      <= 32'd0;
      byte_cnt     <= 2'd0;
      frame_fresh  <= 1'b0;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      checksum_ok  <= 1'b0;
    end else begin
      case (state)
        ST_PAYLOAD: begin
          if (accept) begin
            sum_a       <= a_next;
            sum_b       <= b_next;
            frame_fresh <= 1'b0;
            if (frame_fresh) begin
              checksum_ok <= 1'b0;
            end
            if (last_data) begin
              state    <= ST_TRAILER;
              byte_cnt <= 2'd0;
            end
          end
        end
        ST_TRAILER: begin
          if (accept) begin
            trailer  <= trailer_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state        <= ST_RESULT;
              ready        <= 1'b0;
              result_valid <= 1'b1;
              checksum_ok  <= (trailer_next == {sum_b, sum_a});
            end
          end
        end
        ST_RESULT: begin
          state        <= ST_PAYLOAD;
          ready        <= 1'b1;
          result_valid <= 1'b0;
          frame_fresh  <= 1'b1;
        end
        default: begin
          state        <= ST_PAYLOAD;
          ready        <= 1'b1;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign computed_checksum = {sum_b, sum_a};
  assign received_checksum = trailer;

endmodule
`default_nettype wire
